fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 11 +
 rtl/fetch_stage_pc_register.sv | 27 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and the fetch state type used by the fetch stage.
package fetch_stage_pkg;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter flop with load enable and a redirect/increment next-PC mux.
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load_en,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + 32'd4;
    // Low address bits are forced to zero so the PC stays word aligned.
    assign w_next_pc  = i_redirect ? (i_target & ~32'h3) : o_pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= RESET_VAL & ~32'h3;
        else if (i_load_en)
            r_pc <= w_next_pc;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register and halt detection.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] HALT_INSTR = fetch_stage_pkg::HALT_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
);
    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  w_pc, w_pc_plus4;
    logic         w_pc_load, w_ifid_load, w_ifid_flush;
    logic [31:0]  r_instr, r_pc_plus4;
    logic         r_valid;

    pc_register #(.RESET_VAL(RESET_PC)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load_en  (w_pc_load),
        .i_redirect (branch_taken),
        .i_target   (branch_target),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    // Priority: branch > stall > halted > normal fetch.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_load    = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        if (branch_taken) begin
            w_state_nxt  = ST_RUN;
            w_pc_load    = 1'b1;
            w_ifid_flush = 1'b1;
        end else if (stall) begin
            w_state_nxt = r_state;
        end else if (r_state == ST_HALT) begin
            w_ifid_flush = 1'b1;
        end else begin
            w_ifid_load = 1'b1;
            if (imem_rdata == HALT_INSTR)
                w_state_nxt = ST_HALT;
            else
                w_pc_load = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (w_ifid_flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (w_ifid_load) begin
            r_instr    <= imem_rdata;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign imem_addr      = w_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc_plus4;
    assign if_id_valid    = r_valid;
    assign halted         = (r_state == ST_HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven scoreboard bench for fetch_stage with a small word-indexed instruction memory.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, halted;

    logic [31:0] mem [0:63];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        halted;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];

    assign imem_rdata = mem[imem_addr[7:2]];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " imem_addr"}, imem_addr, e.pc);
        chk({tag, " instr"}, if_id_instr, e.instr);
        chk({tag, " pc_plus4"}, if_id_pc_plus4, e.pp4);
        chk({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
        chk({tag, " halted"}, {31'h0, halted}, {31'h0, e.halted});
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] pp4, input logic v, input logic h);
        exp_t e;
        e.pc = pc; e.instr = instr; e.pp4 = pp4; e.valid = v; e.halted = h;
        return e;
    endfunction

    task automatic add(input logic s, input logic b, input logic [31:0] t,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pp4, input logic v, input logic h);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t;
        r.pc = pc; r.instr = instr; r.pp4 = pp4; r.valid = v; r.halted = h;
        vt.push_back(r);
    endtask

    // Drive one cycle's inputs, push the expectation, compare after the edge.
    task automatic step(input string tag, input vec_t r);
        exp_t e;
        stall         = r.stall;
        branch_taken  = r.br;
        branch_target = r.tgt;
        sb.push_back(mk(r.pc, r.instr, r.pp4, r.valid, r.halted));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h002A_3020;
        mem[4] = 32'hFFFF_FFFF;

        //  stall br  target         pc            instr          pp4           v  h
        add(0, 0, 32'h0,          32'h4,        32'h002A3020, 32'h4,        1, 0);
        add(0, 0, 32'h0,          32'h8,        32'hA0000001, 32'h8,        1, 0);
        add(1, 0, 32'h0,          32'h8,        32'hA0000001, 32'h8,        1, 0);
        add(1, 0, 32'h0,          32'h8,        32'hA0000001, 32'h8,        1, 0);
        add(0, 0, 32'h0,          32'hC,        32'hA0000002, 32'hC,        1, 0);
        add(0, 0, 32'h0,          32'h10,       32'hA0000003, 32'h10,       1, 0);
        add(0, 0, 32'h0,          32'h10,       32'hFFFFFFFF, 32'h14,       1, 1);
        add(0, 0, 32'h0,          32'h10,       32'h0,        32'h0,        0, 1);
        add(1, 0, 32'h0,          32'h10,       32'h0,        32'h0,        0, 1);
        add(0, 1, 32'h20,         32'h20,       32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,          32'h24,       32'hA0000008, 32'h24,       1, 0);
        add(1, 1, 32'h47,         32'h44,       32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,          32'h48,       32'hA0000011, 32'h48,       1, 0);
        add(0, 1, 32'hFFFFFFFC,   32'hFFFFFFFC, 32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,          32'h0,        32'hA000003F, 32'h0,        1, 0);
        add(0, 0, 32'h0,          32'h4,        32'h002A3020, 32'h4,        1, 0);
        add(0, 1, 32'h10,         32'h10,       32'h0,        32'h0,        0, 0);
        add(1, 0, 32'h0,          32'h10,       32'h0,        32'h0,        0, 0);
        add(0, 0, 32'h0,          32'h10,       32'hFFFFFFFF, 32'h14,       1, 1);
        add(0, 0, 32'h0,          32'h10,       32'h0,        32'h0,        0, 1);

        #12;
        chk_all("reset", mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            step($sformatf("vec%0d", i), vt[i]);

        // Async reset while halted, between clock edges.
        @(negedge clk);
        #2;
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        chk_all("rst_held", mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        begin
            vec_t r;
            r.stall = 0; r.br = 0; r.tgt = 32'h0;
            r.pc = 32'h4; r.instr = 32'h002A3020; r.pp4 = 32'h4; r.valid = 1; r.halted = 0;
            step("post_rst", r);
        end

        // Reset asserted during a redirect cycle overrides it.
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_all("rst_vs_branch", mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        branch_taken = 1'b0;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
